// File: rtl/weight_read_scheduler_if.sv
// Handshake bundle between the layer controller (master) and the weight read scheduler (slave).
interface weight_read_scheduler_if #(
   parameter int NUM_BRAMS  = 16,
   parameter int ADDR_WIDTH = 11
);
   logic                            start;
   logic                            mode;
   logic [ADDR_WIDTH-1:0]           base_addr;
   logic [ADDR_WIDTH:0]             num_words;
   logic                            stall;
   logic                            start_conv;
   logic                            start_transconv;
   logic [NUM_BRAMS-1:0]            w_re;
   logic [NUM_BRAMS*ADDR_WIDTH-1:0] w_addr_rd_flat;
   logic [NUM_BRAMS-1:0]            weight_valid;
   logic                            busy;
   logic                            done;

   modport master (
      output start, mode, base_addr, num_words, stall,
      input  start_conv, start_transconv, w_re, w_addr_rd_flat, weight_valid, busy, done
   );

   modport slave (
      input  start, mode, base_addr, num_words, stall,
      output start_conv, start_transconv, w_re, w_addr_rd_flat, weight_valid, busy, done
   );
endinterface

// File: rtl/weight_read_scheduler.sv
// Read sequencer for the banked weight BRAM array (conv / transposed-conv ordering).
// Optional macro WEIGHT_SCHED_SKEW_EN: diagonal systolic skew across banks in conv mode.
module weight_read_scheduler #(
   parameter int NUM_BRAMS  = 16,
   parameter int ADDR_WIDTH = 11
) (
   input logic                    clk,
   input logic                    rst,
   weight_read_scheduler_if.slave bus
);
`ifdef WEIGHT_SCHED_SKEW_EN
   localparam bit SKEW_EN = 1'b1;
`else
   localparam bit SKEW_EN = 1'b0;
`endif
   // Tick counter must reach num_words + NUM_BRAMS - 1 without overflow.
   localparam int TW = ADDR_WIDTH + $clog2(NUM_BRAMS) + 1;

   typedef enum logic [2:0] {S_IDLE, S_MODE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                r_state, w_next;
   logic                  r_mode;
   logic [ADDR_WIDTH-1:0] r_base;
   logic [ADDR_WIDTH:0]   r_num;
   logic [TW-1:0]         r_t;
   logic                  r_start_conv, r_start_transconv, r_busy, r_done;
   logic [NUM_BRAMS-1:0]  r_weight_valid;

   logic                                  w_run, w_last;
   logic [TW-1:0]                         w_skew;
   logic [NUM_BRAMS-1:0]                  w_re;
   logic [NUM_BRAMS-1:0][ADDR_WIDTH-1:0]  w_addr;

   assign w_run  = (r_state == S_RUN);
   assign w_skew = (SKEW_EN && !r_mode) ? TW'(NUM_BRAMS - 1) : '0;
   assign w_last = (r_t == (TW'(r_num) + w_skew - TW'(1)));

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_next = S_MODE;
         S_MODE:  w_next = (r_num == '0) ? S_DONE : S_RUN;
         S_RUN:   if (!bus.stall && w_last) w_next = S_DRAIN;
         S_DRAIN: w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state           <= S_IDLE;
         r_mode            <= 1'b0;
         r_base            <= '0;
         r_num             <= '0;
         r_t               <= '0;
         r_start_conv      <= 1'b0;
         r_start_transconv <= 1'b0;
         r_busy            <= 1'b0;
         r_done            <= 1'b0;
         r_weight_valid    <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && bus.start) begin
            r_mode <= bus.mode;
            r_base <= bus.base_addr;
            r_num  <= bus.num_words;
            r_t    <= '0;
         end else if (w_run && !bus.stall) begin
            r_t <= r_t + TW'(1);
         end
         r_start_conv      <= (r_state == S_IDLE) && bus.start && !bus.mode;
         r_start_transconv <= (r_state == S_IDLE) && bus.start && bus.mode;
         r_busy            <= (w_next != S_IDLE);
         r_done            <= (w_next == S_DONE);
         r_weight_valid    <= w_re;
      end
   end

   // Bank i lags bank 0 by i ticks when skewed; transposed mode walks addresses downward.
   for (genvar i = 0; i < NUM_BRAMS; i++) begin : g_lane
      logic [TW-1:0]         w_lag;
      logic                  w_active;
      logic [ADDR_WIDTH-1:0] w_off;

      assign w_lag    = (SKEW_EN && !r_mode) ? TW'(i) : '0;
      assign w_active = w_run && (r_t >= w_lag) && (r_t < (TW'(r_num) + w_lag));
      assign w_off    = r_mode ? (r_num[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1) - r_t[ADDR_WIDTH-1:0])
                               : (r_t[ADDR_WIDTH-1:0] - w_lag[ADDR_WIDTH-1:0]);
      assign w_re[i]   = w_active && !bus.stall;
      assign w_addr[i] = w_active ? (r_base + w_off) : '0;
   end

   assign bus.w_re            = w_re;
   assign bus.w_addr_rd_flat  = w_addr;
   assign bus.weight_valid    = r_weight_valid;
   assign bus.start_conv      = r_start_conv;
   assign bus.start_transconv = r_start_transconv;
   assign bus.busy            = r_busy;
   assign bus.done            = r_done;
endmodule

// File: tb/tb_weight_read_scheduler.sv
// Directed bench for weight_read_scheduler: per-cycle expected outputs are queued
// before each transaction and popped as the DUT runs.
module tb_weight_read_scheduler;
   localparam int NB = 16;
   localparam int AW = 11;
`ifdef WEIGHT_SCHED_SKEW_EN
   localparam bit SKEW = 1'b1;
`else
   localparam bit SKEW = 1'b0;
`endif

   typedef struct {
      logic [NB-1:0]    re;
      logic [NB*AW-1:0] addr;
      logic [NB-1:0]    vld;
      logic             sc;
      logic             stc;
      logic             busy;
      logic             done;
   } exp_t;

   exp_t          sb[$];
   logic [AW-1:0] b5_addr[$];
   int            first_re15;
   int            checks = 0;
   int            errors = 0;
   logic          clk = 1'b0;
   logic          rst = 1'b1;

   weight_read_scheduler_if #(.NUM_BRAMS(NB), .ADDR_WIDTH(AW)) bus ();
   weight_read_scheduler #(.NUM_BRAMS(NB), .ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [NB*AW-1:0] obs, input logic [NB*AW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t zero_exp();
      exp_t e;
      e.re = '0; e.addr = '0; e.vld = '0;
      e.sc = 1'b0; e.stc = 1'b0; e.busy = 1'b0; e.done = 1'b0;
      return e;
   endfunction

   // Expected trace from the start cycle c through one idle cycle after done.
   task automatic build(input bit m, input int base, input int n, input int st_at, input int st_len);
      exp_t          e;
      logic [NB-1:0] prev;
      int            s, t, off, lag;
      bit            stl;
      e = zero_exp(); sb.push_back(e);
      e.sc = !m; e.stc = m; e.busy = 1'b1; sb.push_back(e);
      prev = '0;
      if (n != 0) begin
         s = (!m && SKEW) ? NB - 1 : 0;
         t = 0; off = 2;
         for (int k = 0; k < 5000; k++) begin
            stl = (off >= st_at) && (off < st_at + st_len);
            e = zero_exp(); e.busy = 1'b1; e.vld = prev;
            for (int i = 0; i < NB; i++) begin
               lag = (!m && SKEW) ? i : 0;
               if (t >= lag && t < n + lag) begin
                  e.addr[i*AW +: AW] = AW'(m ? (base + n - 1 - t) : (base + t - lag));
                  e.re[i] = !stl;
               end
            end
            sb.push_back(e);
            prev = e.re;
            off++;
            if (!stl) begin
               if (t == n + s - 1) break;
               t++;
            end
         end
         e = zero_exp(); e.busy = 1'b1; e.vld = prev; sb.push_back(e);
      end
      e = zero_exp(); e.busy = 1'b1; e.done = 1'b1; sb.push_back(e);
      e = zero_exp(); sb.push_back(e);
   endtask

   task automatic cmp_cycle(input string tag);
      exp_t e;
      e = sb.pop_front();
      chk({tag, ".w_re"},   NB*AW'(bus.w_re),         NB*AW'(e.re));
      chk({tag, ".addr"},   bus.w_addr_rd_flat,       e.addr);
      chk({tag, ".valid"},  NB*AW'(bus.weight_valid), NB*AW'(e.vld));
      chk({tag, ".sconv"},  NB*AW'(bus.start_conv),   NB*AW'(e.sc));
      chk({tag, ".stconv"}, NB*AW'(bus.start_transconv), NB*AW'(e.stc));
      chk({tag, ".busy"},   NB*AW'(bus.busy),         NB*AW'(e.busy));
      chk({tag, ".done"},   NB*AW'(bus.done),         NB*AW'(e.done));
   endtask

   task automatic run_txn(input string tag, input bit m, input int base, input int n,
                          input int st_at, input int st_len, input int ss_off, input int exp_done);
      int len, done_at;
      sb.delete();
      b5_addr.delete();
      first_re15 = -1;
      build(m, base, n, st_at, st_len);
      len = sb.size();
      done_at = -1;
      for (int off = 0; off < len; off++) begin
         @(posedge clk); #1;
         bus.start     = (off == 0) || (off == ss_off);
         bus.mode      = (off == 0) ? m : ~m;
         bus.base_addr = (off == 0) ? AW'(base) : AW'(11'h155);
         bus.num_words = (off == 0) ? (AW+1)'(n) : (AW+1)'(7);
         bus.stall     = (off >= st_at) && (off < st_at + st_len);
         #2;
         if (bus.done === 1'b1 && done_at < 0) done_at = off;
         if (bus.w_re[5] === 1'b1) b5_addr.push_back(bus.w_addr_rd_flat[5*AW +: AW]);
         if (bus.w_re[15] === 1'b1 && first_re15 < 0) first_re15 = off;
         cmp_cycle(tag);
      end
      chk({tag, ".done_cycle"}, NB*AW'(done_at), NB*AW'(exp_done));
      @(posedge clk); #1;
      bus.start = 1'b0; bus.stall = 1'b0;
   endtask

   logic [AW-1:0] wrap_exp [4];

   initial begin
      wrap_exp[0] = 11'h001; wrap_exp[1] = 11'h000; wrap_exp[2] = 11'h7FF; wrap_exp[3] = 11'h7FE;
      bus.start = 1'b0; bus.mode = 1'b0; bus.base_addr = '0; bus.num_words = '0; bus.stall = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #3;
      chk("rst.w_re",  NB*AW'(bus.w_re), '0);
      chk("rst.addr",  bus.w_addr_rd_flat, '0);
      chk("rst.valid", NB*AW'(bus.weight_valid), '0);
      chk("rst.pulse", NB*AW'({bus.start_conv, bus.start_transconv}), '0);
      chk("rst.busy_done", NB*AW'({bus.busy, bus.done}), '0);
      @(posedge clk); #1; rst = 1'b0;

      // Conv, base 0x010, N=4
      run_txn("conv4", 1'b0, 'h010, 4, -1, 0, -1, SKEW ? 22 : 7);
      chk("conv4.bank15_first", NB*AW'(first_re15), NB*AW'(SKEW ? 17 : 2));

      // Transposed, wrap-around, with an ignored second start mid-run
      run_txn("tconv_wrap", 1'b1, 'h7FE, 4, -1, 0, 3, 7);
      chk("tconv_wrap.b5_count", NB*AW'(b5_addr.size()), NB*AW'(4));
      for (int i = 0; i < 4; i++)
         if (i < b5_addr.size()) chk("tconv_wrap.b5_addr", NB*AW'(b5_addr[i]), NB*AW'(wrap_exp[i]));

      // Conv, N=3, stall for 2 cycles at c+3
      run_txn("conv_stall", 1'b0, 'h020, 3, 3, 2, -1, SKEW ? 2 + 3 + 15 + 1 + 2 : 2 + 3 + 1 + 2);
      chk("conv_stall.b5_second", NB*AW'(b5_addr.size() > 1 ? b5_addr[1] : 11'h7FF), NB*AW'(11'h021));

      // N=0: pulse only, no reads
      run_txn("conv_n0", 1'b0, 'h100, 0, -1, 0, -1, 2);
      run_txn("tconv_n0", 1'b1, 'h100, 0, -1, 0, -1, 2);

      // Conv N=2 (parallel in the unskewed build)
      run_txn("conv2", 1'b0, 'h3F0, 2, -1, 0, -1, SKEW ? 2 + 2 + 15 + 1 : 5);

      // Reset mid-RUN aborts without done
      @(posedge clk); #1;
      bus.start = 1'b1; bus.mode = 1'b1; bus.base_addr = 11'h100; bus.num_words = 12'd6;
      @(posedge clk); #1; bus.start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1; #2;
      chk("abort.run_re", NB*AW'(bus.w_re), NB*AW'({NB{1'b1}}));
      chk("abort.run_addr0", NB*AW'(bus.w_addr_rd_flat[0 +: AW]), NB*AW'(11'h104));
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0; #2;
      chk("abort.w_re",  NB*AW'(bus.w_re), '0);
      chk("abort.addr",  bus.w_addr_rd_flat, '0);
      chk("abort.valid", NB*AW'(bus.weight_valid), '0);
      chk("abort.flags", NB*AW'({bus.start_conv, bus.start_transconv, bus.busy, bus.done}), '0);
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #3;
         chk("abort.quiet", NB*AW'({bus.busy, bus.done}), '0);
      end

      // Fresh start after abort
      run_txn("post_abort", 1'b1, 'h040, 3, -1, 0, -1, 6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
